wmt_flow_calc: RTL and testbench

WMT_FLOW_CALC -- requirements
Module: wmt_flow_calc

---
 rtl/wmt_flow_calc_pkg.sv | 27 ++
 rtl/wmt_div24.sv | 75 +++++++
 rtl/wmt_flow_calc.sv | 175 +++++++++++++++++
 tb/tb_wmt_flow_calc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wmt_flow_calc_pkg.sv
// ----------------------------------------------------------------------------
// wmt_flow_calc_pkg : shared constants, state encoding and helpers (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package wmt_flow_calc_pkg;

  localparam int SAMPLE_US  = 20000;
  localparam int AVG_DEPTH  = 8;
  localparam int LOW_CNT    = 3;
  localparam int DIV_CYCLES = 24;
  localparam int SUM_W      = 19;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_SAMPLE = 4'b0010,
    S_DIVIDE = 4'b0100,
    S_DONE   = 4'b1000
  } state_e;

  function automatic logic [15:0] sat16(input logic [23:0] q);
    return (q > 24'h00FFFF) ? 16'hFFFF : q[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/wmt_div24.sv
// ----------------------------------------------------------------------------
// wmt_div24 : restoring serial divider, 24/16 bit, saturating quotient (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module wmt_div24
  import wmt_flow_calc_pkg::*;
(
  input  logic        clk_1us,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [23:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic [15:0] quotient_o,
  output logic        done_o
);

  logic        active_q;
  logic [4:0]  cnt_q;
  logic [15:0] rem_q;
  logic [23:0] quo_q;
  logic [15:0] dvs_q;

  logic [16:0] shift_w;
  logic [16:0] diff_w;
  logic        ge_w;
  logic [15:0] rem_d;
  logic [23:0] quo_d;

  // Borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    shift_w = {rem_q, quo_q[23]};
    diff_w  = shift_w - {1'b0, dvs_q};
    ge_w    = ~diff_w[16];
    rem_d   = ge_w ? diff_w[15:0] : shift_w[15:0];
    quo_d   = {quo_q[22:0], ge_w};
  end

  // Quotient is presented from the final step so the caller can capture it on done.
  assign done_o     = active_q && (cnt_q == 5'(DIV_CYCLES - 1));
  assign quotient_o = sat16(quo_d);

  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (abort_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= dividend_i;
      dvs_q    <= divisor_i;
    end else if (active_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 5'd1;
      if (done_o) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wmt_flow_calc.sv
// ----------------------------------------------------------------------------
// wmt_flow_calc : 8-sample meter-period average converted to flow (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module wmt_flow_calc
  import wmt_flow_calc_pkg::*;
#(
  parameter int SAMPLE_PERIOD = SAMPLE_US
) (
  input  logic        clk_1us,
  input  logic        rstn_i,
  input  logic        flow_en,
  input  logic [15:0] wmt_data,
  input  logic        wmt_err,
  input  logic [23:0] flow_k,
  input  logic [15:0] flow_low_thd,
  output logic [15:0] flow_data,
  output logic        flow_valid,
  output logic        flow_low,
  output logic        busy
);

  localparam int TW = $clog2(SAMPLE_PERIOD);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q;
  logic [15:0]      buf_q [AVG_DEPTH];
  logic [2:0]       wptr_q;
  logic [3:0]       fill_q;
  logic [3:0]       zcnt_q;
  logic [SUM_W-1:0] sum_q;
  logic [15:0]      flow_data_q;
  logic             flow_low_q;
  logic [1:0]       below_q;

  logic             tick_w;
  logic [15:0]      sample_w, old_w, avg_w, result_w, div_quot_w;
  logic [SUM_W-1:0] sum_new_w;
  logic [3:0]       fill_new_w, zcnt_new_w;
  logic             full_w, zero_path_w;
  logic             div_start_w, div_done_w, load_w;
  logic [1:0]       below_inc_w;

  assign tick_w = flow_en && (timer_q == TW'(SAMPLE_PERIOD - 1));

  // Window bookkeeping after the write this SAMPLE cycle would perform.
  // Slots not yet written hold 0 but were never counted as zero samples.
  always_comb begin
    sample_w    = (wmt_err || (wmt_data == 16'd0)) ? 16'd0 : wmt_data;
    old_w       = buf_q[wptr_q];
    full_w      = (fill_q == 4'(AVG_DEPTH));
    sum_new_w   = sum_q + SUM_W'(sample_w) - SUM_W'(old_w);
    fill_new_w  = full_w ? fill_q : fill_q + 4'd1;
    zcnt_new_w  = zcnt_q + {3'd0, (sample_w == 16'd0)} - {3'd0, (full_w && (old_w == 16'd0))};
    avg_w       = sum_new_w[SUM_W-1:3];
    zero_path_w = (zcnt_new_w != 4'd0) || (avg_w == 16'd0);
    below_inc_w = (below_q == 2'(LOW_CNT)) ? below_q : below_q + 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    div_start_w = 1'b0;
    load_w      = 1'b0;
    result_w    = 16'd0;
    case (state_q)
      S_IDLE: begin
        if (tick_w) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (fill_new_w != 4'(AVG_DEPTH)) begin
          state_d = S_IDLE;
        end else if (zero_path_w) begin
          state_d = S_DONE;
          load_w  = 1'b1;
        end else begin
          state_d     = S_DIVIDE;
          div_start_w = 1'b1;
        end
      end
      S_DIVIDE: begin
        if (div_done_w) begin
          state_d  = S_DONE;
          load_w   = 1'b1;
          result_w = div_quot_w;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!flow_en) begin
      state_d     = S_IDLE;
      div_start_w = 1'b0;
      load_w      = 1'b0;
    end
  end

  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i)                                  timer_q <= '0;
    else if (!flow_en)                            timer_q <= '0;
    else if (timer_q == TW'(SAMPLE_PERIOD - 1))   timer_q <= '0;
    else                                          timer_q <= timer_q + TW'(1);
  end

  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < AVG_DEPTH; i++) buf_q[i] <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      zcnt_q <= '0;
      sum_q  <= '0;
    end else if (!flow_en) begin
      for (int i = 0; i < AVG_DEPTH; i++) buf_q[i] <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      zcnt_q <= '0;
      sum_q  <= '0;
    end else if (state_q == S_SAMPLE) begin
      buf_q[wptr_q] <= sample_w;
      wptr_q        <= wptr_q + 3'd1;
      fill_q        <= fill_new_w;
      zcnt_q        <= zcnt_new_w;
      sum_q         <= sum_new_w;
    end
  end

  // flow_data lands on DONE entry so it is stable while flow_valid is high;
  // the threshold compare runs during DONE against that captured value.
  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i) begin
      flow_data_q <= '0;
      flow_low_q  <= 1'b0;
      below_q     <= '0;
    end else if (!flow_en) begin
      flow_data_q <= '0;
      flow_low_q  <= 1'b0;
      below_q     <= '0;
    end else begin
      if (load_w) flow_data_q <= result_w;
      if (state_q == S_DONE) begin
        if (flow_data_q < flow_low_thd) begin
          below_q <= below_inc_w;
          if (below_inc_w == 2'(LOW_CNT)) flow_low_q <= 1'b1;
        end else begin
          below_q    <= '0;
          flow_low_q <= 1'b0;
        end
      end
    end
  end

  wmt_div24 u_div (
    .clk_1us    (clk_1us),
    .rstn_i     (rstn_i),
    .start_i    (div_start_w),
    .abort_i    (!flow_en),
    .dividend_i (flow_k),
    .divisor_i  (avg_w),
    .quotient_o (div_quot_w),
    .done_o     (div_done_w)
  );

  assign flow_data  = flow_data_q;
  assign flow_valid = (state_q == S_DONE);
  assign flow_low   = flow_low_q;
  assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_wmt_flow_calc.sv
// ----------------------------------------------------------------------------
// tb_wmt_flow_calc : directed vector bench for wmt_flow_calc (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wmt_flow_calc;

  localparam int PERIOD   = 64;
  localparam int LAT_NONE = -1;
  localparam int LAT_ZERO = 1;
  localparam int LAT_DIV  = 25;

  logic        clk_1us = 1'b0;
  logic        rstn_i;
  logic        flow_en;
  logic [15:0] wmt_data;
  logic        wmt_err;
  logic [23:0] flow_k;
  logic [15:0] flow_low_thd;
  logic [15:0] flow_data;
  logic        flow_valid;
  logic        flow_low;
  logic        busy;

  wmt_flow_calc #(.SAMPLE_PERIOD(PERIOD)) dut (
    .clk_1us      (clk_1us),
    .rstn_i       (rstn_i),
    .flow_en      (flow_en),
    .wmt_data     (wmt_data),
    .wmt_err      (wmt_err),
    .flow_k       (flow_k),
    .flow_low_thd (flow_low_thd),
    .flow_data    (flow_data),
    .flow_valid   (flow_valid),
    .flow_low     (flow_low),
    .busy         (busy)
  );

  always #5 clk_1us = ~clk_1us;

  int cyc = 0;
  always @(posedge clk_1us) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic [23:0] k;
    logic [15:0] thd;
    int          lat;
    logic [15:0] flow;
    logic        low;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_cyc = 0;
  int   valid_cyc = 0;

  task automatic add(input logic [15:0] d, input logic e, input logic [23:0] k,
                     input logic [15:0] t, input int l, input logic [15:0] f, input logic lw);
    vec_t v;
    v.data = d; v.err = e; v.k = k; v.thd = t; v.lat = l; v.flow = f; v.low = lw;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One tick window: drive inputs, find SAMPLE, classify the outcome by latency.
  task automatic run_vec(input int i);
    int lat;
    bit seen;
    wmt_data     = vecs[i].data;
    wmt_err      = vecs[i].err;
    flow_k       = vecs[i].k;
    flow_low_thd = vecs[i].thd;
    seen = 1'b0;
    for (int n = 0; n < 4 * PERIOD && !seen; n++) begin
      @(negedge clk_1us);
      seen = busy;
    end
    if (!seen) begin
      check($sformatf("v%0d_tick_timeout", i), 0, 1);
      return;
    end
    busy_cyc = cyc;
    lat = -2;
    for (int n = 1; n <= 40 && lat == -2; n++) begin
      @(negedge clk_1us);
      if (flow_valid) begin
        lat = n;
        valid_cyc = cyc;
      end else if (!busy) begin
        lat = LAT_NONE;
      end
    end
    check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
    if (lat > 0) check($sformatf("v%0d_flow", i), flow_data, vecs[i].flow);
    @(negedge clk_1us);
    check($sformatf("v%0d_low", i), flow_low, vecs[i].low);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_a;
    int first_busy;
    int en_cyc;
    int hits;
    bit seen;
    logic [15:0] ramp [8];
    logic [15:0] back [8];

    // Window of 1000s, then 2000s entering one per tick, then 1000s again.
    ramp = '{16'd888, 16'd800, 16'd727, 16'd666, 16'd615, 16'd571, 16'd533, 16'd500};
    back = '{16'd533, 16'd571, 16'd615, 16'd666, 16'd727, 16'd800, 16'd888, 16'd1000};
    for (int i = 0; i < 7; i++) add(16'd1000, 1'b0, 24'd1000000, 16'd0, LAT_NONE, 16'd0, 1'b0);
    add(16'd1000, 1'b0, 24'd1000000, 16'd0, LAT_DIV, 16'd1000, 1'b0);
    for (int i = 0; i < 8; i++) add(16'd2000, 1'b0, 24'd1000000, 16'd0, LAT_DIV, ramp[i], 1'b0);
    for (int i = 0; i < 8; i++) add(16'd1000, 1'b0, 24'd1000000, 16'd0, LAT_DIV, back[i], 1'b0);
    add(16'd1000, 1'b1, 24'd1000000, 16'd0, LAT_ZERO, 16'd0, 1'b0);
    for (int i = 0; i < 7; i++) add(16'd1000, 1'b0, 24'd1000000, 16'd0, LAT_ZERO, 16'd0, 1'b0);
    add(16'd1000, 1'b0, 24'd1000000, 16'd0, LAT_DIV, 16'd1000, 1'b0);
    add(16'd1000, 1'b0, 24'd1000000, 16'd2000, LAT_DIV, 16'd1000, 1'b0);
    add(16'd1000, 1'b0, 24'd1000000, 16'd2000, LAT_DIV, 16'd1000, 1'b0);
    add(16'd1000, 1'b0, 24'd1000000, 16'd2000, LAT_DIV, 16'd1000, 1'b1);
    add(16'd1000, 1'b0, 24'd2000000, 16'd2000, LAT_DIV, 16'd2000, 1'b0);
    n_a = vecs.size();
    for (int i = 0; i < 7; i++) add(16'd1, 1'b0, 24'hFFFFFF, 16'd0, LAT_NONE, 16'd0, 1'b0);
    add(16'd1, 1'b0, 24'hFFFFFF, 16'd0, LAT_DIV, 16'hFFFF, 1'b0);
    add(16'd0, 1'b0, 24'hFFFFFF, 16'd0, LAT_ZERO, 16'd0, 1'b0);
    add(16'd5, 1'b0, 24'hFFFFFF, 16'd0, LAT_ZERO, 16'd0, 1'b0);

    rstn_i = 1'b0; flow_en = 1'b1; wmt_data = '0; wmt_err = 1'b0;
    flow_k = '0; flow_low_thd = '0;
    repeat (3) @(negedge clk_1us);
    check("rst_flow_data", flow_data, 0);
    check("rst_flow_valid", flow_valid, 0);
    check("rst_flow_low", flow_low, 0);
    check("rst_busy", busy, 0);
    rstn_i = 1'b1;

    first_busy = 0;
    for (int i = 0; i < n_a; i++) begin
      run_vec(i);
      if (i == 1) check("tick_period", busy_cyc - first_busy, PERIOD);
      first_busy = busy_cyc;
    end

    // Drop enable ten cycles after the tick, inside the divide.
    wmt_data = 16'd1000; wmt_err = 1'b0; flow_k = 24'd1000000; flow_low_thd = 16'd0;
    seen = 1'b0;
    for (int n = 0; n < 4 * PERIOD && !seen; n++) begin
      @(negedge clk_1us);
      seen = busy;
    end
    check("abort_tick_seen", seen, 1);
    repeat (9) @(negedge clk_1us);
    check("abort_in_divide", busy, 1);
    flow_en = 1'b0;
    @(negedge clk_1us);
    check("abort_flow_data", flow_data, 0);
    check("abort_flow_valid", flow_valid, 0);
    check("abort_flow_low", flow_low, 0);
    check("abort_busy", busy, 0);
    hits = 0;
    repeat (3 * PERIOD) begin
      @(negedge clk_1us);
      if (flow_valid) hits++;
    end
    check("abort_no_valid", hits, 0);

    flow_en = 1'b1;
    en_cyc = cyc;
    for (int i = n_a; i < n_a + 8; i++) run_vec(i);
    check("reenable_gap", (valid_cyc - en_cyc) >= 8 * PERIOD, 1);
    for (int i = n_a + 8; i < vecs.size(); i++) run_vec(i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
